cache_response_generator: RTL and testbench



---
 rtl/cache_response_generator.sv | 135 +++++++++++++
 tb/tb_cache_response_generator.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_response_generator.sv
// Pairs in-order cache read responses with the requestor IDs recorded at issue time
// and returns each one through a per-requestor valid/ready port.
module cache_response_generator #(
    parameter int unsigned NUM_MEMORY_REQUESTOR = 2,
    parameter int unsigned DATA_WIDTH           = 512,
    parameter int unsigned FIFO_DEPTH           = 16,
    localparam int unsigned ID_WIDTH  = (NUM_MEMORY_REQUESTOR > 1) ? $clog2(NUM_MEMORY_REQUESTOR) : 1,
    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                            ap_clk,
    input  logic                            areset,
    input  logic                            req_issue_valid,
    input  logic [ID_WIDTH-1:0]             req_issue_id,
    output logic                            req_issue_ready,
    input  logic                            cache_resp_valid,
    input  logic [DATA_WIDTH-1:0]           cache_resp_rdata,
    output logic                            cache_resp_ready,
    output logic [NUM_MEMORY_REQUESTOR-1:0] mem_resp_valid,
    output logic [DATA_WIDTH-1:0]           mem_resp_data,
    input  logic [NUM_MEMORY_REQUESTOR-1:0] mem_resp_ready,
    output logic [CNT_WIDTH-1:0]            outstanding_count,
    output logic                            error_orphan
);

    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    localparam logic [1:0] RESP_RESET = 2'd0;
    localparam logic [1:0] RESP_IDLE  = 2'd1;
    localparam logic [1:0] RESP_BUSY  = 2'd2;

    logic [ID_WIDTH-1:0]   tag_mem_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];

    logic [1:0]            state_q, state_d;
    logic [PTR_WIDTH-1:0]  tag_wr_ptr_q, tag_wr_ptr_d, tag_rd_ptr_q, tag_rd_ptr_d;
    logic [PTR_WIDTH-1:0]  data_wr_ptr_q, data_wr_ptr_d, data_rd_ptr_q, data_rd_ptr_d;
    logic [CNT_WIDTH-1:0]  tag_cnt_q, tag_cnt_d, data_cnt_q, data_cnt_d;
    logic [CNT_WIDTH-1:0]  data_avail_q, data_avail_d;
    logic                  data_push_q;
    logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;
    logic                  orphan_q, orphan_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic issue, accept, orphan, data_push, pair_avail, pop, sel_ready;

    always_comb begin
        req_issue_ready  = (state_q != RESP_RESET) && (tag_cnt_q != FULL_CNT);
        cache_resp_ready = (state_q != RESP_RESET) && (data_cnt_q != FULL_CNT);
        issue      = req_issue_valid & req_issue_ready;
        accept     = cache_resp_valid & cache_resp_ready;
        orphan     = accept && (outstanding_q == '0) && !issue;
        data_push  = accept & ~orphan;
        // The reader sees a data entry one cycle after it is written (registered write port).
        pair_avail = (tag_cnt_q != '0) && (data_avail_q != '0);
        sel_ready  = mem_resp_ready[id_q];
        pop        = pair_avail && ((state_q == RESP_IDLE) || ((state_q == RESP_BUSY) && sel_ready));
    end

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        data_d        = data_q;
        tag_wr_ptr_d  = issue ? tag_wr_ptr_q + PTR_ONE : tag_wr_ptr_q;
        tag_rd_ptr_d  = pop ? tag_rd_ptr_q + PTR_ONE : tag_rd_ptr_q;
        data_wr_ptr_d = data_push ? data_wr_ptr_q + PTR_ONE : data_wr_ptr_q;
        data_rd_ptr_d = pop ? data_rd_ptr_q + PTR_ONE : data_rd_ptr_q;
        tag_cnt_d     = tag_cnt_q + CNT_WIDTH'(issue) - CNT_WIDTH'(pop);
        data_cnt_d    = data_cnt_q + CNT_WIDTH'(data_push) - CNT_WIDTH'(pop);
        data_avail_d  = data_avail_q + CNT_WIDTH'(data_push_q) - CNT_WIDTH'(pop);
        outstanding_d = outstanding_q + CNT_WIDTH'(issue) - CNT_WIDTH'(data_push);
        orphan_d      = orphan_q | orphan;
        if (pop) begin
            id_d   = tag_mem_q[tag_rd_ptr_q];
            data_d = data_mem_q[data_rd_ptr_q];
        end
        case (state_q)
            RESP_RESET: state_d = RESP_IDLE;
            RESP_IDLE:  if (pop) state_d = RESP_BUSY;
            RESP_BUSY:  if (sel_ready && !pair_avail) state_d = RESP_IDLE;
            default:    state_d = RESP_RESET;
        endcase
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state_q       <= RESP_RESET;
            tag_wr_ptr_q  <= '0;
            tag_rd_ptr_q  <= '0;
            data_wr_ptr_q <= '0;
            data_rd_ptr_q <= '0;
            tag_cnt_q     <= '0;
            data_cnt_q    <= '0;
            data_avail_q  <= '0;
            data_push_q   <= 1'b0;
            outstanding_q <= '0;
            orphan_q      <= 1'b0;
            id_q          <= '0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            tag_wr_ptr_q  <= tag_wr_ptr_d;
            tag_rd_ptr_q  <= tag_rd_ptr_d;
            data_wr_ptr_q <= data_wr_ptr_d;
            data_rd_ptr_q <= data_rd_ptr_d;
            tag_cnt_q     <= tag_cnt_d;
            data_cnt_q    <= data_cnt_d;
            data_avail_q  <= data_avail_d;
            data_push_q   <= data_push;
            outstanding_q <= outstanding_d;
            orphan_q      <= orphan_d;
            id_q          <= id_d;
            data_q        <= data_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (issue)     tag_mem_q[tag_wr_ptr_q]   <= req_issue_id;
        if (data_push) data_mem_q[data_wr_ptr_q] <= cache_resp_rdata;
    end

    always_comb begin
        mem_resp_valid = '0;
        for (int unsigned i = 0; i < NUM_MEMORY_REQUESTOR; i++) begin
            mem_resp_valid[i] = (state_q == RESP_BUSY) && (id_q == ID_WIDTH'(i));
        end
    end

    assign mem_resp_data     = data_q;
    assign outstanding_count = outstanding_q;
    assign error_orphan      = orphan_q;

endmodule

// File: tb/tb_cache_response_generator.sv
// Randomized and directed bench for cache_response_generator against a queue-based
// model of in-order tag/data pairing, outstanding count and orphan detection.
module tb_cache_response_generator;

    localparam int NUM = 2;
    localparam int DW  = 512;
    localparam int IDW = 1;
    localparam int CW  = 5;

    logic           ap_clk = 1'b0;
    logic           areset = 1'b1;
    logic           req_issue_valid = 1'b0;
    logic [IDW-1:0] req_issue_id = '0;
    logic           req_issue_ready;
    logic           cache_resp_valid = 1'b0;
    logic [DW-1:0]  cache_resp_rdata = '0;
    logic           cache_resp_ready;
    logic [NUM-1:0] mem_resp_valid;
    logic [DW-1:0]  mem_resp_data;
    logic [NUM-1:0] mem_resp_ready = '0;
    logic [CW-1:0]  outstanding_count;
    logic           error_orphan;

    cache_response_generator #(
        .NUM_MEMORY_REQUESTOR(NUM),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(16)
    ) dut (
        .ap_clk(ap_clk),
        .areset(areset),
        .req_issue_valid(req_issue_valid),
        .req_issue_id(req_issue_id),
        .req_issue_ready(req_issue_ready),
        .cache_resp_valid(cache_resp_valid),
        .cache_resp_rdata(cache_resp_rdata),
        .cache_resp_ready(cache_resp_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data),
        .mem_resp_ready(mem_resp_ready),
        .outstanding_count(outstanding_count),
        .error_orphan(error_orphan)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model: issued IDs and accepted data pair up strictly in arrival order.
    logic [IDW-1:0] tagq[$];
    logic [DW-1:0]  dq[$];
    int             cnt_m = 0;
    logic           orphan_m = 1'b0;

    always @(negedge ap_clk) begin
        logic           iss, acc;
        logic [NUM-1:0] exp_valid;
        if (areset) begin
            tagq.delete();
            dq.delete();
            cnt_m    = 0;
            orphan_m = 1'b0;
        end else begin
            check_eq("outstanding", DW'(outstanding_count), DW'(cnt_m));
            check_eq("orphan_flag", DW'(error_orphan), DW'(orphan_m));
            if (mem_resp_valid != '0) begin
                if (tagq.size() == 0 || dq.size() == 0) begin
                    check_eq("spurious_valid", DW'(mem_resp_valid), '0);
                end else begin
                    exp_valid = '0;
                    exp_valid[tagq[0]] = 1'b1;
                    check_eq("valid_id", DW'(mem_resp_valid), DW'(exp_valid));
                    check_eq("resp_data", mem_resp_data, dq[0]);
                    if ((mem_resp_valid & mem_resp_ready) != '0) begin
                        void'(tagq.pop_front());
                        void'(dq.pop_front());
                    end
                end
            end
            iss = req_issue_valid & req_issue_ready;
            acc = cache_resp_valid & cache_resp_ready;
            if (iss) tagq.push_back(req_issue_id);
            if (acc && cnt_m == 0 && !iss) begin
                orphan_m = 1'b1;
            end else begin
                if (acc) dq.push_back(cache_resp_rdata);
                cnt_m = cnt_m + int'(iss) - int'(acc);
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_issue_valid  = 1'b0;
        cache_resp_valid = 1'b0;
    endtask

    task automatic wait_drain();
        logic timed_out;
        idle_inputs();
        mem_resp_ready = '1;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tagq.size() == 0 && dq.size() == 0 && mem_resp_valid == '0) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        check_eq("drain_timeout", DW'(timed_out), '0);
    endtask

    logic [DW-1:0] pat;
    logic [DW-1:0] d[4];
    int            first, k, accepts, issues;
    logic          seen;

    initial begin
        // Reset state
        #1;
        check_eq("rst_issue_ready", DW'(req_issue_ready), '0);
        check_eq("rst_cache_ready", DW'(cache_resp_ready), '0);
        check_eq("rst_valid", DW'(mem_resp_valid), '0);
        check_eq("rst_data", mem_resp_data, '0);
        check_eq("rst_outstanding", DW'(outstanding_count), '0);
        check_eq("rst_orphan", DW'(error_orphan), '0);
        tick();
        tick();
        areset = 1'b0;
        check_eq("rel_issue_ready", DW'(req_issue_ready), '0);
        tick();
        check_eq("idle_issue_ready", DW'(req_issue_ready), DW'(1));
        check_eq("idle_cache_ready", DW'(cache_resp_ready), DW'(1));

        // Single request, latency of two edges after response accept
        pat = {64{8'hA5}};
        req_issue_valid = 1'b1;
        req_issue_id    = 1'b1;
        tick();
        req_issue_valid = 1'b0;
        check_eq("single_outst1", DW'(outstanding_count), DW'(1));
        tick();
        tick();
        cache_resp_valid = 1'b1;
        cache_resp_rdata = pat;
        tick();
        cache_resp_valid = 1'b0;
        check_eq("single_outst0", DW'(outstanding_count), '0);
        check_eq("lat_t0", DW'(mem_resp_valid), '0);
        tick();
        check_eq("lat_t1", DW'(mem_resp_valid), '0);
        tick();
        check_eq("lat_t2_valid", DW'(mem_resp_valid), DW'(2'b10));
        check_eq("lat_t2_data", mem_resp_data, pat);
        wait_drain();

        // Interleaved ids with back-to-back delivery
        for (int i = 0; i < 4; i++) begin
            req_issue_valid = 1'b1;
            req_issue_id    = IDW'(i % 2);
            d[i]            = rand_data();
            tick();
        end
        req_issue_valid = 1'b0;
        mem_resp_ready  = 2'b11;
        k     = 0;
        first = -1;
        for (int c = 0; c < 16; c++) begin
            cache_resp_valid = (c < 4);
            if (c < 4) cache_resp_rdata = d[c];
            tick();
            if (mem_resp_valid != '0 && k < 4) begin
                if (first < 0) first = c;
                check_eq("ilv_b2b", DW'(c - first), DW'(k));
                check_eq("ilv_valid", DW'(mem_resp_valid), (k % 2 == 0) ? DW'(2'b01) : DW'(2'b10));
                check_eq("ilv_data", mem_resp_data, d[k]);
                k++;
            end
        end
        check_eq("ilv_count", DW'(k), DW'(4));
        wait_drain();

        // Backpressure on requestor 0 until the data FIFO fills
        mem_resp_ready = 2'b10;
        accepts = 0;
        issues  = 0;
        for (int c = 0; c < 40; c++) begin
            req_issue_valid  = req_issue_ready && (issues < 17);
            req_issue_id     = '0;
            cache_resp_valid = (cnt_m > 0) || req_issue_valid;
            cache_resp_rdata = rand_data();
            if (req_issue_valid) issues++;
            if (cache_resp_valid && cache_resp_ready) accepts++;
            tick();
        end
        idle_inputs();
        check_eq("bp_accepts", DW'(accepts), DW'(17));
        check_eq("bp_cache_ready", DW'(cache_resp_ready), '0);
        for (int c = 0; c < 5; c++) tick();
        check_eq("bp_hold_valid", DW'(mem_resp_valid), DW'(2'b01));
        check_eq("bp_cache_ready_held", DW'(cache_resp_ready), '0);
        wait_drain();

        // Tag FIFO full
        mem_resp_ready = 2'b11;
        for (int i = 0; i < 16; i++) begin
            req_issue_valid = 1'b1;
            req_issue_id    = IDW'($urandom_range(0, 1));
            tick();
        end
        req_issue_valid = 1'b0;
        check_eq("tagfull_ready", DW'(req_issue_ready), '0);
        check_eq("tagfull_outst", DW'(outstanding_count), DW'(16));
        cache_resp_valid = 1'b1;
        cache_resp_rdata = rand_data();
        tick();
        cache_resp_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = req_issue_ready;
        end
        check_eq("tagfull_ready_back", DW'(seen), DW'(1));
        for (int i = 0; i < 15; i++) begin
            cache_resp_valid = 1'b1;
            cache_resp_rdata = rand_data();
            tick();
        end
        wait_drain();

        // Orphan response
        check_eq("orph_pre_outst", DW'(outstanding_count), '0);
        cache_resp_valid = 1'b1;
        cache_resp_rdata = rand_data();
        tick();
        cache_resp_valid = 1'b0;
        check_eq("orph_set", DW'(error_orphan), DW'(1));
        check_eq("orph_outst", DW'(outstanding_count), '0);
        for (int c = 0; c < 5; c++) tick();
        check_eq("orph_sticky", DW'(error_orphan), DW'(1));
        check_eq("orph_no_valid", DW'(mem_resp_valid), '0);

        // Reset with responses queued
        mem_resp_ready = '0;
        for (int i = 0; i < 3; i++) begin
            req_issue_valid  = 1'b1;
            req_issue_id     = IDW'(i % 2);
            cache_resp_valid = 1'b1;
            cache_resp_rdata = rand_data();
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) tick();
        areset = 1'b1;
        #1;
        check_eq("mrst_valid", DW'(mem_resp_valid), '0);
        check_eq("mrst_data", mem_resp_data, '0);
        check_eq("mrst_outst", DW'(outstanding_count), '0);
        check_eq("mrst_orphan", DW'(error_orphan), '0);
        check_eq("mrst_issue_ready", DW'(req_issue_ready), '0);
        check_eq("mrst_cache_ready", DW'(cache_resp_ready), '0);
        tick();
        tick();
        areset = 1'b0;
        check_eq("mrst_rel_ready", DW'(cache_resp_ready), '0);
        tick();
        check_eq("mrst_ready_back", DW'(cache_resp_ready), DW'(1));
        mem_resp_ready = '1;
        for (int c = 0; c < 10; c++) tick();
        check_eq("mrst_no_stale", DW'(mem_resp_valid), '0);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            req_issue_valid  = req_issue_ready && ($urandom_range(0, 1) == 1);
            req_issue_id     = IDW'($urandom_range(0, 1));
            cache_resp_valid = ((cnt_m > 0) || req_issue_valid) && ($urandom_range(0, 2) != 0);
            cache_resp_rdata = rand_data();
            mem_resp_ready   = NUM'($urandom_range(0, 3));
            tick();
        end
        while (cnt_m > 0) begin
            req_issue_valid  = 1'b0;
            cache_resp_valid = 1'b1;
            cache_resp_rdata = rand_data();
            mem_resp_ready   = '1;
            tick();
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
